// File: rtl/tl_cmd_master.sv
// Expands host requests into command sequences for the light controller.
// Optional TL_CMD_MASTER_DEDUP_EN drops START/OFF/SERVICE already in effect.
module tl_cmd_master #(
    parameter int CMD_GAP = 2,
    parameter int DATA_W  = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [DATA_W-1:0] req_green_i,
    input  logic [DATA_W-1:0] req_red_i,
    input  logic [DATA_W-1:0] req_yellow_i,
    output logic              cmd_valid_o,
    output logic [2:0]        cmd_type_o,
    output logic [DATA_W-1:0] cmd_data_o,
    output logic              done_o,
    output logic [1:0]        mode_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE_ON, S_PRE_SVC, S_WR_G, S_WR_R,
        S_WR_Y, S_POST, S_SINGLE, S_GAP
    } state_e;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_OFF   = 2'd1;
    localparam logic [1:0] OP_SVC   = 2'd2;
    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_RUN    = 2'd1;
    localparam logic [1:0] M_SVC    = 2'd2;
    localparam logic [7:0] GAP_LD   = (CMD_GAP == 0) ? 8'd0 : 8'(CMD_GAP - 1);
`ifdef TL_CMD_MASTER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    state_e state_q, state_d, step_q, step_d, nxt, first;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d, omode_q, omode_d, mode_q;
    logic [DATA_W-1:0] g_q, g_d, r_q, r_d, y_q, y_d;

    // Step following cur; cur == S_IDLE yields the first step of a request.
    function automatic state_e plan(
        input state_e            cur,
        input logic [1:0]        op,
        input logic [1:0]        om,
        input logic [DATA_W-1:0] g,
        input logic [DATA_W-1:0] r,
        input logic [DATA_W-1:0] y
    );
        state_e tail, from_y, from_r, from_g, res;
        tail   = (om == M_SVC) ? S_IDLE : S_POST;
        from_y = (y != '0) ? S_WR_Y : tail;
        from_r = (r != '0) ? S_WR_R : from_y;
        from_g = (g != '0) ? S_WR_G : from_r;
        res    = S_IDLE;
        case (cur)
            S_IDLE: begin
                case (op)
                    OP_START: res = (DEDUP && om == M_RUN) ? S_IDLE : S_SINGLE;
                    OP_OFF:   res = (DEDUP && om == M_OFF) ? S_IDLE : S_SINGLE;
                    OP_SVC: begin
                        if (om == M_OFF)               res = S_PRE_ON;
                        else if (DEDUP && om == M_SVC) res = S_IDLE;
                        else                           res = S_SINGLE;
                    end
                    default: begin
                        if (om == M_OFF)      res = S_PRE_ON;
                        else if (om == M_RUN) res = S_PRE_SVC;
                        else                  res = from_g;
                    end
                endcase
            end
            S_PRE_ON:  res = S_PRE_SVC;
            S_PRE_SVC: res = (op == OP_SVC) ? S_IDLE : from_g;
            S_WR_G:    res = from_r;
            S_WR_R:    res = from_y;
            S_WR_Y:    res = tail;
            default:   res = S_IDLE;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= S_IDLE;
            step_q  <= S_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 2'd0;
            omode_q <= M_SVC;
            mode_q  <= M_SVC;
            g_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            omode_q <= omode_d;
            mode_q  <= mode_o;
            g_q     <= g_d;
            r_q     <= r_d;
            y_q     <= y_d;
        end
    end

    assign nxt   = plan(state_q, op_q, omode_q, g_q, r_q, y_q);
    assign first = plan(S_IDLE, req_op_i, mode_q,
                        req_green_i, req_red_i, req_yellow_i);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        omode_d = omode_q;
        g_d     = g_q;
        r_d     = r_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    omode_d = mode_q;
                    g_d     = req_green_i;
                    r_d     = req_red_i;
                    y_d     = req_yellow_i;
                    if (first == S_IDLE) begin
                        // Empty sequence: one gap cycle carries the done pulse.
                        state_d = S_GAP;
                        step_d  = S_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = first;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) state_d = step_q;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: begin
                if (CMD_GAP == 0) begin
                    state_d = nxt;
                end else begin
                    state_d = S_GAP;
                    step_d  = nxt;
                    cnt_d   = GAP_LD;
                end
            end
        endcase
    end

    always_comb begin
        cmd_valid_o = 1'b0;
        cmd_type_o  = 3'd0;
        cmd_data_o  = '0;
        done_o      = 1'b0;
        req_ready_o = (state_q == S_IDLE);
        case (state_q)
            S_PRE_ON:  cmd_valid_o = 1'b1;
            S_PRE_SVC: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = 3'd2;
            end
            S_WR_G: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = 3'd3;
                cmd_data_o  = g_q;
            end
            S_WR_R: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = 3'd4;
                cmd_data_o  = r_q;
            end
            S_WR_Y: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = 3'd5;
                cmd_data_o  = y_q;
            end
            S_POST: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = (omode_q == M_RUN) ? 3'd0 : 3'd1;
            end
            S_SINGLE: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = (op_q == OP_START) ? 3'd0 :
                              (op_q == OP_OFF)   ? 3'd1 : 3'd2;
            end
            S_GAP:   done_o = (cnt_q == 8'd0) && (step_q == S_IDLE);
            default: ;
        endcase
        if (cmd_valid_o && CMD_GAP == 0 && nxt == S_IDLE) done_o = 1'b1;
        mode_o = mode_q;
        if (cmd_valid_o) begin
            case (cmd_type_o)
                3'd0:    mode_o = M_RUN;
                3'd1:    mode_o = M_OFF;
                3'd2:    mode_o = M_SVC;
                default: mode_o = mode_q;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_cmd_master.sv
// Scoreboard bench for tl_cmd_master: a request-level model queues the
// expected strobes and done pulses; a negedge monitor checks them.
module tb_tl_cmd_master;
    localparam int GAP = 2;
    localparam int DW  = 16;
`ifdef TL_CMD_MASTER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [DW-1:0] req_g = '0, req_r = '0, req_y = '0;
    logic          cmd_valid;
    logic [2:0]    cmd_type;
    logic [DW-1:0] cmd_data;
    logic          done;
    logic [1:0]    mode;

    tl_cmd_master #(.CMD_GAP(GAP), .DATA_W(DW)) dut (
        .clk_i(clk), .srst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_green_i(req_g),
        .req_red_i(req_r), .req_yellow_i(req_y),
        .cmd_valid_o(cmd_valid), .cmd_type_o(cmd_type),
        .cmd_data_o(cmd_data), .done_o(done), .mode_o(mode)
    );

    typedef struct { int ty; int data; int cyc; } cmd_t;
    typedef struct { int cyc; int mode; } done_t;
    cmd_t  exp_q[$];
    done_t done_q[$];
    cmd_t  ec;
    done_t ed;

    int npass = 0, ntot = 0, cyc = 0, ndone = 0;
    int m_mode = 2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", int'(cmd_type), -1);
                end else begin
                    ec = exp_q.pop_front();
                    check("cmd_type", int'(cmd_type), ec.ty);
                    check("cmd_data", int'(cmd_data), ec.data);
                    check("cmd_cycle", cyc, ec.cyc);
                end
            end else begin
                check("idle_cmd_zero", int'({cmd_type, cmd_data}), 0);
            end
            if (done) begin
                ndone++;
                if (done_q.size() == 0) begin
                    check("unexpected_done", cyc, -1);
                end else begin
                    ed = done_q.pop_front();
                    check("done_cycle", cyc, ed.cyc);
                    check("mode_at_done", int'(mode), ed.mode);
                end
            end
        end
    end

    // Request-level reference: command list from the op and current mode.
    task automatic model(input int op, input int g, input int r,
                         input int y, input int acc);
        int ty[$];
        int dt[$];
        int n;
        int m0;
        m0 = m_mode;
        case (op)
            0: if (!(DEDUP && m0 == 1)) begin ty.push_back(0); dt.push_back(0); end
            1: if (!(DEDUP && m0 == 0)) begin ty.push_back(1); dt.push_back(0); end
            2: begin
                if (m0 == 0) begin
                    ty.push_back(0); dt.push_back(0);
                    ty.push_back(2); dt.push_back(0);
                end else if (!(DEDUP && m0 == 2)) begin
                    ty.push_back(2); dt.push_back(0);
                end
            end
            default: begin
                if (m0 == 0) begin ty.push_back(0); dt.push_back(0); end
                if (m0 != 2) begin ty.push_back(2); dt.push_back(0); end
                if (g != 0) begin ty.push_back(3); dt.push_back(g); end
                if (r != 0) begin ty.push_back(4); dt.push_back(r); end
                if (y != 0) begin ty.push_back(5); dt.push_back(y); end
                if (m0 == 1) begin ty.push_back(0); dt.push_back(0); end
                if (m0 == 0) begin ty.push_back(1); dt.push_back(0); end
            end
        endcase
        n = ty.size();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{ty[k], dt[k], acc + 1 + k * (GAP + 1)});
            if (ty[k] == 0) m_mode = 1;
            else if (ty[k] == 1) m_mode = 0;
            else if (ty[k] == 2) m_mode = 2;
        end
        done_q.push_back('{acc + ((n == 0) ? 1 : n * (GAP + 1)), m_mode});
    endtask

    // Called and returns #1 after a rising edge.
    task automatic do_req(input int op, input int g, input int r,
                          input int y, input bit wait_done);
        bit got;
        int d0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!got) begin
            check("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_op = op[1:0];
        req_g = g[DW-1:0];
        req_r = r[DW-1:0];
        req_y = y[DW-1:0];
        model(op, g, r, y, cyc);
        d0 = ndone;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 2'($urandom_range(0, 3));
        check("ready_low_after_accept", int'(req_ready), 0);
        if (wait_done) begin
            for (int i = 0; i < 300; i++) begin
                if (ndone != d0) break;
                @(posedge clk); #1;
            end
            if (ndone == d0) check("done_timeout", 0, 1);
        end
    endtask

    function automatic int rfield();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 65535));
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(req_ready), 1);
        check("rst_mode", int'(mode), 2);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(3, 100, 50, 10, 1);
        check("mode_after_cfg_svc", int'(mode), 2);
        do_req(0, 0, 0, 0, 1);
        do_req(3, 0, 30, 0, 1);
        check("mode_after_cfg_run", int'(mode), 1);
        do_req(1, 0, 0, 0, 1);
        do_req(2, 0, 0, 0, 1);
        check("mode_after_svc_from_off", int'(mode), 2);
        do_req(1, 0, 0, 0, 1);
        do_req(3, 0, 0, 0, 1);
        check("mode_after_cfg_off", int'(mode), 0);
        do_req(0, 0, 0, 0, 1);
        do_req(0, 0, 0, 0, 1);
        do_req(2, 0, 0, 0, 1);
        do_req(2, 0, 0, 0, 1);

        // Reset while the first write strobe is on the bus.
        do_req(0, 0, 0, 0, 1);
        do_req(3, 7, 8, 9, 0);
        repeat (3) @(posedge clk);
        #2;
        check("mid_cfg_write_strobe", int'(cmd_valid), 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(cmd_valid), 0);
        exp_q.delete();
        done_q.delete();
        m_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_ready", int'(req_ready), 1);
        check("post_rst_mode", int'(mode), 2);
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            do_req(int'($urandom_range(0, 3)), rfield(), rfield(), rfield(), 1);
            check("mode_track", int'(mode), m_mode);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size() + done_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
